// File: rtl/cpu_bus_ram_target_pkg.sv
// Shared definitions for CPU bus responder blocks.
// Holds the responder handshake state encoding, so that every
// peripheral target on the CPU request/ready bus uses the same states.
package cpu_bus_ram_target_pkg;

  // Responder handshake states:
  // - IDLE: waiting for a request.
  // - WAIT: inserting wait states.
  // - RESP: ready pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_target_state_t;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/cpu_bus_ram_array.sv
// Single-port synchronous word RAM with a registered read port.
// A write and a read of the same word on the same edge return the old contents.
// The memory has no reset, so it can map onto block RAM.
// Ports:
//   i_clock      - rising-edge clock
//   write_enable - commit wdata to mem[index] on this edge
//   index        - word index
//   wdata        - write data
//   rdata        - registered read data (mem[index] as seen before this edge)
module cpu_bus_ram_array
  import cpu_bus_ram_target_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic                  i_clock,
  input  logic                  write_enable,
  input  logic [SIZE-1:0]       index,
  input  logic [BUS_DATA_W-1:0] wdata,
  output logic [BUS_DATA_W-1:0] rdata
);

  logic [BUS_DATA_W-1:0] mem_r [0:(2**SIZE)-1];

  // Memory write and read-before-write output register.
  always_ff @(posedge i_clock) begin
    if (write_enable) begin
      mem_r[index] <= wdata;
    end
    rdata <= mem_r[index];
  end

endmodule

// File: rtl/cpu_bus_ram_target.sv
// On-chip RAM responder for the CPU request/ready bus.
// It accepts one word read or write per handshake.
// It decodes the address against a fixed window.
// After WAIT_STATES extra cycles it answers with a single-cycle ready pulse.
// An access outside the window completes with o_error set.
// Ports:
//   i_clock, i_reset           - clock, synchronous active-high reset
//   i_bus_request, i_bus_rw    - request strobe, 1 = write / 0 = read
//   i_bus_address, i_bus_wdata - byte address (bits [1:0] ignored), write data
//   o_bus_ready                - completion pulse
//   o_bus_rdata, o_error       - response data / out-of-window flag; 0 when not ready
module cpu_bus_ram_target
  import cpu_bus_ram_target_pkg::*;
#(
  parameter int          SIZE        = 10,
  parameter logic [31:0] BASE        = 32'h2000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ERROR_VALUE = 32'hDEAD_BEEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_bus_rw,
  input  logic        i_bus_request,
  output logic        o_bus_ready,
  input  logic [31:0] i_bus_address,
  output logic [31:0] o_bus_rdata,
  input  logic [31:0] i_bus_wdata,
  output logic        o_error
);

  localparam logic                  HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : {WAIT_CNT_W{1'b0}};

  bus_target_state_t     state_r, state_s;
  logic [WAIT_CNT_W-1:0] wait_cnt_r, wait_cnt_s;
  logic                  rw_r, hit_r;
  logic [SIZE-1:0]       index_r;

  logic                  hit_s, accept_s, ram_we_s;
  logic [SIZE-1:0]       bus_index_s, ram_index_s;
  logic [31:0]           ram_rdata_s;
  logic                  unused_addr_s;

  assign hit_s         = (i_bus_address[31:SIZE+2] == BASE[31:SIZE+2]);
  assign bus_index_s   = i_bus_address[SIZE+1:2];
  assign unused_addr_s = ^i_bus_address[1:0];
  assign accept_s      = (state_r == IDLE) && i_bus_request;
  // A write commits on the accepting edge. A reset on that same edge suppresses the write.
  assign ram_we_s      = accept_s && hit_s && i_bus_rw && !i_reset;
  // After acceptance, the RAM keeps re-reading the latched word.
  // Its registered output is then still valid when RESP arrives after any number of wait states.
  assign ram_index_s   = accept_s ? bus_index_s : index_r;

  cpu_bus_ram_array #(
    .SIZE (SIZE)
  ) u_ram (
    .i_clock      (i_clock),
    .write_enable (ram_we_s),
    .index        (ram_index_s),
    .wdata        (i_bus_wdata),
    .rdata        (ram_rdata_s)
  );

  // State, wait counter and per-transaction attribute registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WAIT_CNT_W{1'b0}};
      rw_r       <= 1'b0;
      hit_r      <= 1'b0;
      index_r    <= {SIZE{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (accept_s) begin
        rw_r    <= i_bus_rw;
        hit_r   <= hit_s;
        index_r <= bus_index_s;
      end
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    case (state_r)
      IDLE: begin
        if (i_bus_request) begin
          if (HAS_WAIT) begin
            state_s    = WAIT;
            wait_cnt_s = WAIT_LOAD;
          end else begin
            state_s = RESP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == {WAIT_CNT_W{1'b0}}) begin
          state_s = RESP;
        end else begin
          wait_cnt_s = wait_cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      // A request still high here belongs to the completing transaction.
      RESP: state_s = IDLE;
      default: begin
        state_s    = IDLE;
        wait_cnt_s = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // Response outputs, decoded from state and latched attributes only.
  always_comb begin
    o_bus_ready = 1'b0;
    o_bus_rdata = 32'h0000_0000;
    o_error     = 1'b0;
    if (state_r == RESP) begin
      o_bus_ready = 1'b1;
      o_error     = !hit_r;
      if (rw_r) begin
        o_bus_rdata = 32'h0000_0000;
      end else if (hit_r) begin
        o_bus_rdata = ram_rdata_s;
      end else begin
        o_bus_rdata = ERROR_VALUE;
      end
    end else begin
      o_bus_ready = 1'b0;
    end
  end

endmodule
